// File: rtl/mem_lsu_pp.sv
// MEM-stage load/store unit: byte-addressed requests in, word accesses to a
// combinational-read / posedge-write data RAM, sub-word stores via read-modify-write.

module mem_lsu_lane (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       en,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module mem_lsu_pp #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] read_data
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        sz;
    logic              sg;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wdata;
  } req_t;

  state_t state, state_nx;
  req_t   q;
  logic [31:0] old_w, merged, sh, load_ext;
  logic acc, acc_err;

  assign acc     = req_valid && req_ready;
  assign acc_err = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && (req_addr[1:0] != 2'b00)) ||
                   (|req_addr[31:ADDR_W+2]);

  assign req_ready = (state == IDLE) && !reset;
  assign MemRead   = (state == RD) && !reset;
  assign MemWrite  = (state == WR) && !reset;
  assign address   = {{(32-ADDR_W){1'b0}}, q.idx};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc && !acc_err)
                 state_nx = (req_write && req_size == 2'd2) ? WR : RD;
      RD:      state_nx = q.wr ? MERGE : IDLE;
      MERGE:   state_nx = WR;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Sub-word lane is aligned for legal halves, so one byte-granular shift serves all sizes
  assign sh = read_data >> {q.lane, 3'b000};
  always_comb begin
    load_ext = read_data;
    case (q.sz)
      2'd0:    load_ext = {{24{q.sg & sh[7]}},  sh[7:0]};
      2'd1:    load_ext = {{16{q.sg & sh[15]}}, sh[15:0]};
      default: load_ext = read_data;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic       en;
    logic [7:0] nb;
    assign en = (q.sz == 2'd0) ? (q.lane == 2'(i)) :
                (q.sz == 2'd1) ? (q.lane[1] == 1'(i / 2)) : 1'b1;
    assign nb = (q.sz == 2'd0) ? q.wdata[7:0] :
                (q.sz == 2'd1) ? q.wdata[(i%2)*8 +: 8] : q.wdata[i*8 +: 8];
    mem_lsu_lane u_lane (
      .old_b (old_w[i*8 +: 8]),
      .new_b (nb),
      .en    (en),
      .out_b (merged[i*8 +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      write_data <= '0;
      old_w      <= '0;
      q          <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (acc_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else begin
            q <= '{wr: req_write, sz: req_size, sg: req_signed, lane: req_addr[1:0],
                   idx: req_addr[ADDR_W+1:2], wdata: req_wdata};
            if (req_write && req_size == 2'd2) write_data <= req_wdata;
          end
        end
        RD: begin
          if (q.wr) old_w <= read_data;
          else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= load_ext;
          end
        end
        MERGE: write_data <= merged;
        WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu_pp.sv
// Bench for mem_lsu_pp: byte-array memory model, directed cases then random requests.

module tb_mem_lsu_pp;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, MemWrite, MemRead;
  logic [31:0] resp_data, address, write_data, read_data;

  logic [31:0] ram [32];
  logic [7:0]  rm  [128];
  int n_chk = 0, n_pass = 0, wr_seen = 0;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  mem_lsu_pp #(.ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .address(address),
    .write_data(write_data), .MemWrite(MemWrite), .MemRead(MemRead),
    .read_data(read_data)
  );

  assign read_data = ram[address[4:0]];
  always @(posedge clk) begin
    if (MemWrite) begin
      ram[address[4:0]] <= write_data;
      wr_seen <= wr_seen + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mword(input int i);
    return {rm[4*i+3], rm[4*i+2], rm[4*i+1], rm[4*i]};
  endfunction

  task automatic set_word(input int i, input logic [31:0] v);
    ram[i] = v;
    for (int k = 0; k < 4; k++) rm[4*i+k] = v[8*k +: 8];
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic err;
    logic [31:0] exp_d, exp_w;
    int ai, nb, idx, exp_lat, n, nrd, nwr;
    bit got;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a > 32'd127);
    ai = int'(a[6:0]);
    idx = ai / 4;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_d = 0;
    if (!err && !w) begin
      for (int k = 0; k < nb; k++) exp_d = exp_d + (32'(rm[ai+k]) << (8*k));
      if (sg && nb == 1 && exp_d[7])  exp_d = exp_d - 32'h100;
      if (sg && nb == 2 && exp_d[15]) exp_d = exp_d - 32'h10000;
    end
    if (!err && w) for (int k = 0; k < nb; k++) rm[ai+k] = wd[8*k +: 8];
    exp_w = mword(idx);
    exp_lat = err ? 1 : (w && nb < 4) ? 4 : 2;

    @(negedge clk);
    chk("pulse_end", 32'(resp_valid), 0);
    chk("ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    got = 0; n = 0; nrd = 0; nwr = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (MemRead && MemWrite) chk("rd_wr_excl", 1, 0);
      if (MemRead) begin nrd++; chk("rd_addr", address, 32'(idx)); end
      if (MemWrite) begin
        nwr++;
        chk("wr_addr", address, 32'(idx));
        chk("wr_data", write_data, exp_w);
      end
      if (resp_valid) got = 1;
    end
    if (!got) chk("resp_timeout", 0, 1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_data", resp_data, exp_d);
    chk("n_memread", 32'(nrd), (err || (w && nb == 4)) ? 0 : 1);
    chk("n_memwrite", 32'(nwr), (!err && w) ? 1 : 0);
    if (!err && w) chk("ram_word", ram[idx], mword(idx));
    last_data = resp_data;
  endtask

  initial begin
    int ws;
    for (int i = 0; i < 32; i++) set_word(i, $urandom);
    set_word(5, 32'd109); set_word(7, 32'd5); set_word(0, 32'd50); set_word(1, 32'd51);

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rd", 32'(MemRead), 0);
    chk("rst_wr", 32'(MemWrite), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", write_data, 0);
    reset = 1'b0;

    do_req(0, 2'd2, 0, 32'h14, 0);          chk("lw5_lit", last_data, 32'd109);
    do_req(1, 2'd0, 0, 32'h1D, 32'hFF);     chk("sb_ram7", ram[7], 32'h0000FF05);
    do_req(0, 2'd0, 1, 32'h1D, 0);          chk("lb_lit", last_data, 32'hFFFFFFFF);
    do_req(0, 2'd0, 0, 32'h1D, 0);          chk("lbu_lit", last_data, 32'h000000FF);
    do_req(0, 2'd2, 0, 32'h1C, 0);          chk("lw7_lit", last_data, 32'h0000FF05);
    do_req(1, 2'd1, 0, 32'h16, 32'h1234);   chk("sh_ram5", ram[5], 32'h1234006D);
    do_req(0, 2'd1, 1, 32'h16, 0);          chk("lh_lit", last_data, 32'h00001234);
    do_req(0, 2'd2, 0, 32'h16, 0);
    do_req(0, 2'd1, 0, 32'h15, 0);
    do_req(0, 2'd3, 0, 32'h00, 0);
    do_req(0, 2'd2, 0, 32'h80, 0);
    do_req(1, 2'd2, 0, 32'h18, 32'hDEADBEEF);

    // reset while the merge is in flight
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h1C; req_wdata = 32'hAA;
    @(posedge clk); #1 req_valid = 1'b0; ws = wr_seen;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("mrst_ready", 32'(req_ready), 1);
    chk("mrst_valid", 32'(resp_valid), 0);
    @(negedge clk);
    chk("mrst_nowr", 32'(wr_seen - ws), 0);
    chk("mrst_ram7", ram[7], mword(7));

    // reset while the write itself is pending
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h1C; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0; ws = wr_seen;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    chk("wrst_memwrite", 32'(MemWrite), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("wrst_nowr", 32'(wr_seen - ws), 0);
    chk("wrst_ram7", ram[7], mword(7));
    chk("wrst_valid", 32'(resp_valid), 0);

    // back-to-back loads with req_valid held high
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h00;
    @(posedge clk); #1 req_addr = 32'h04;
    @(negedge clk);
    chk("b2b_busy", 32'(req_ready), 0);
    @(negedge clk);
    chk("b2b_v1", 32'(resp_valid), 1);
    chk("b2b_d1", resp_data, 32'd50);
    chk("b2b_rdy", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_gap", 32'(resp_valid), 0);
    chk("b2b_rd", 32'(MemRead), 1);
    chk("b2b_addr", address, 1);
    @(negedge clk);
    chk("b2b_v2", 32'(resp_valid), 1);
    chk("b2b_d2", resp_data, 32'd51);

    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) a = a | (32'h80 << $urandom_range(0, 24));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_lsu_pp.md
Name: mem_lsu_pp

Overview:
- Load/store unit for the MEM stage of the pipelined processor.
- It is the initiator side of the data-RAM interface. It drives word address, write_data, MemWrite and MemRead into the word-organised data RAM, which has a combinational read and a posedge write.
- It converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses. Sub-word stores use read-modify-write.
- It returns load data or a store acknowledge through a valid/ready handshake toward the pipeline.

Parameters:
- ADDR_W, 5, log2 of RAM depth in words (32 words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  pipeline presents a memory request
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  input  1  sign-extend a sub-word load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle pulse: load data or store done
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid: misaligned, illegal size, or out of range
- address  output  32  word index to the RAM, zero-extended
- write_data  output  32  word to the RAM
- MemWrite  output  1  RAM write enable
- MemRead  output  1  RAM read enable
- read_data  input  32  RAM read word, valid in the same cycle MemRead is high

Behaviour:
- Reset, synchronous and active-high:
  - state = IDLE.
  - resp_valid, resp_err, resp_data, address and write_data all = 0.
  - Reset takes priority over every other event, including an in-flight request.
- States: IDLE, RD, MERGE, WR.
- req_ready = (state == IDLE) and not reset. A request is accepted on an edge where req_valid and req_ready are both 1. All request fields are latched at that edge.
- Word index = req_addr[ADDR_W+1:2]. This index is driven onto address, zero-extended, from the cycle after acceptance.
- Lanes are little-endian: the byte lane is addr[1:0] and the half lane is addr[1].
- Error conditions, checked at acceptance:
  - size = 3;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr[31:ADDR_W+2] != 0.
  - On error: no RAM access. State stays IDLE. In the next cycle resp_valid = 1, resp_err = 1, resp_data = 0.
- Load: IDLE --accept--> RD.
  - In RD: MemRead = 1. read_data is sampled at the end of RD.
  - The selected lane is zero- or sign-extended to 32 bits. A word load passes the whole word through.
  - RD -> IDLE. resp_valid = 1 with resp_data in the following cycle.
  - Latency: resp_valid occurs 2 cycles after the accept edge.
- Word store: IDLE --accept--> WR.
  - In WR: MemWrite = 1 and write_data = req_wdata. The RAM commits at the end of WR.
  - WR -> IDLE with resp_valid = 1 and resp_data = 0. Latency 2.
- Sub-word store: IDLE --accept--> RD, then MERGE, then WR, then IDLE.
  - RD: MemRead = 1; the old word is captured at the end of RD.
  - MERGE: the byte or half is inserted into the captured word. Other lanes are unchanged.
  - WR: writes the merged word.
  - Latency: 4 cycles from accept to resp_valid.
- MemRead = (state == RD) and not reset. MemWrite = (state == WR) and not reset. MemRead and MemWrite are never high together. No write may commit on an edge where reset is high.
- While outside IDLE, req_valid is ignored and req_ready = 0. A new request may be accepted in the same cycle that resp_valid is high.
- resp_valid is exactly one cycle per accepted request. resp_data and resp_err hold their value until the next response.

Test Plan:
- RAM[5] = 109: LW 0x14 -> MemRead high for 1 cycle at address 5; resp_data = 109; resp_valid exactly 2 cycles after accept; resp_err = 0.
- RAM[7] = 5: SB 0x1D with wdata = 0x000000FF -> RD, MERGE, WR at address 7 with write_data = 0x0000FF05. Then LB signed 0x1D -> 0xFFFFFFFF. Then LBU 0x1D -> 0x000000FF. Then LW 0x1C -> 0x0000FF05.
- SH 0x16 with wdata = 0x1234 over RAM[5] = 0x6D -> RAM[5] = 0x1234006D. Then LH signed 0x16 -> 0x00001234.
- Errors: LW 0x16, LH 0x15, size = 3, LW 0x80 -> each gives resp_valid = 1 and resp_err = 1 one cycle after accept; MemRead and MemWrite stay 0.
- Reset asserted during MERGE of SB 0x1C -> MemWrite never rises; RAM[7] unchanged; the cycle after reset, req_ready = 1 and resp_valid = 0.
- Back-to-back: hold req_valid high with LW 0x00 then LW 0x04 (RAM = 50, 51) -> the second request is accepted in the same cycle as the first resp_valid; responses are 50 then 51 on consecutive response pulses.
